// File: rtl/mult4_seq_if.sv
// Groups the multiply request (start/a/b) and result (busy/done/p) signals.
// master drives the request side; slave is the multiplier.
interface mult4_seq_if;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] p;

    modport master (output start, output a, output b,
                    input  busy,  input  done, input  p);
    modport slave  (input  start, input  a, input  b,
                    output busy,  output done, output p);
endinterface

// File: rtl/mult4_seq.sv
// Sequential 4x4 unsigned shift-and-add multiplier sharing one 4-bit adder over four steps.
// Latency 4 cycles from start acceptance to done; start is ignored while busy.
module adder4bits (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [4:0] o_sum
);
    assign o_sum = {1'b0, i_a} + {1'b0, i_b};
endmodule

module mult4_seq (
    input  logic        clk,
    input  logic        rst_n,
    mult4_seq_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_hi;
    logic [3:0] r_lo;
    logic [3:0] r_mcand;
    logic [1:0] r_cnt;
    logic [7:0] r_p;
    logic [3:0] w_addend;
    logic [4:0] w_sum;
    logic       w_accept;
    logic       w_busy;
    logic       w_done;

    assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_addend = r_lo[0] ? r_mcand : 4'b0000;

    adder4bits u_adder (
        .i_a   (r_hi),
        .i_b   (w_addend),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = bus.start ? S_RUN : S_IDLE;
            S_RUN:   w_next_state = (r_cnt == 2'd3) ? S_DONE : S_RUN;
            S_DONE:  w_next_state = bus.start ? S_RUN : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_RUN:   w_busy = 1'b1;
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    // Each step shifts {carry, sum, lo} right by one; p only moves on the last step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hi    <= 4'd0;
            r_lo    <= 4'd0;
            r_mcand <= 4'd0;
            r_cnt   <= 2'd0;
            r_p     <= 8'h00;
        end else if (w_accept) begin
            r_mcand <= bus.a;
            r_hi    <= 4'd0;
            r_lo    <= bus.b;
            r_cnt   <= 2'd0;
        end else if (r_state == S_RUN) begin
            r_hi  <= w_sum[4:1];
            r_lo  <= {w_sum[0], r_lo[3:1]};
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
                r_p <= {w_sum[4:1], w_sum[0], r_lo[3:1]};
            end
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.p    = r_p;
endmodule

// File: tb/tb_mult4_seq.sv
// Directed and randomized checks of mult4_seq against a plain a*b reference.
module tb_mult4_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;

    mult4_seq_if bus ();

    mult4_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One complete operation with idle start afterwards; noisy toggles start/operands during RUN.
    task automatic do_op(input logic [3:0] ta, input logic [3:0] tb, input bit noisy);
        logic [7:0] exp_p;
        exp_p     = 8'(ta) * 8'(tb);
        bus.a     = ta;
        bus.b     = tb;
        bus.start = 1'b1;
        tick();
        check("accept_busy", 8'(bus.busy), 8'd1);
        for (int i = 1; i <= 3; i++) begin
            bus.start = noisy && (i < 3);
            if (noisy) begin
                bus.a = 4'($urandom);
                bus.b = 4'($urandom);
            end
            tick();
            check("run_busy", 8'(bus.busy), 8'd1);
            check("run_done", 8'(bus.done), 8'd0);
        end
        bus.start = 1'b0;
        tick();
        check("done_pulse", 8'(bus.done), 8'd1);
        check("done_busy", 8'(bus.busy), 8'd0);
        check("product", bus.p, exp_p);
        tick();
        check("done_width", 8'(bus.done), 8'd0);
        check("no_extra_busy", 8'(bus.busy), 8'd0);
        check("p_hold", bus.p, exp_p);
    endtask

    initial begin
        logic [7:0] exp_q[$];
        logic [7:0] exp_p;
        int         gap;
        int         n_done;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = 4'd0;
        bus.b     = 4'd0;
        tick();
        tick();
        check("rst_busy", 8'(bus.busy), 8'd0);
        check("rst_done", 8'(bus.done), 8'd0);
        check("rst_p", bus.p, 8'h00);
        rst_n = 1'b1;
        tick();

        do_op(4'd3, 4'd5, 1'b0);
        do_op(4'd15, 4'd15, 1'b0);
        do_op(4'd0, 4'd9, 1'b0);
        do_op(4'd9, 4'd1, 1'b0);
        do_op(4'd1, 4'd15, 1'b0);

        // Requests and operand changes during RUN must not disturb 7*6.
        bus.a     = 4'd7;
        bus.b     = 4'd6;
        bus.start = 1'b1;
        tick();
        bus.a = 4'd2;
        bus.b = 4'd2;
        tick();
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("ign_done", 8'(bus.done), 8'd1);
        check("ign_p", bus.p, 8'd42);
        tick();
        check("ign_busy_after", 8'(bus.busy), 8'd0);
        check("ign_done_after", 8'(bus.done), 8'd0);

        // Back-to-back with start held high.
        bus.a     = 4'd4;
        bus.b     = 4'd4;
        bus.start = 1'b1;
        tick();
        bus.a = 4'd10;
        bus.b = 4'd12;
        for (int i = 0; i < 4; i++) tick();
        check("b2b_done1", 8'(bus.done), 8'd1);
        check("b2b_p1", bus.p, 8'd16);
        gap = 0;
        tick();
        gap++;
        check("b2b_rebusy", 8'(bus.busy), 8'd1);
        bus.start = 1'b0;
        while (!bus.done && gap < 20) begin
            tick();
            gap++;
        end
        check("b2b_period", 8'(gap), 8'd5);
        check("b2b_p2", bus.p, 8'd120);
        tick();

        // Reset in the middle of an operation.
        do_op(4'd2, 4'd3, 1'b0);
        bus.a     = 4'd5;
        bus.b     = 4'd5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_busy", 8'(bus.busy), 8'd0);
        check("abort_done", 8'(bus.done), 8'd0);
        check("abort_p", bus.p, 8'd0);
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.done) n_done++;
        end
        check("abort_no_done", 8'(n_done), 8'd0);
        check("abort_p_hold", bus.p, 8'd0);
        do_op(4'd5, 4'd5, 1'b0);

        // Randomized operations, some with noise on the request side during RUN.
        for (int i = 0; i < 20; i++) begin
            do_op(4'($urandom), 4'($urandom), 1'($urandom));
        end

        // Exhaustive sweep with start held high, accepted at every DONE edge.
        bus.start = 1'b1;
        for (int k = 0; k < 256; k++) begin
            bus.a = 4'(k >> 4);
            bus.b = 4'(k);
            exp_q.push_back(8'(k >> 4) * 8'(k & 15));
            tick();
            for (int i = 0; i < 4; i++) tick();
            check("sweep_done", 8'(bus.done), 8'd1);
            exp_p = exp_q.pop_front();
            check("sweep_p", bus.p, exp_p);
        end
        bus.start = 1'b0;
        tick();
        check("sweep_idle", 8'(bus.busy), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
